// File: rtl/commit_trace_buffer_if.sv
// Commit trace bundle: processor capture side, reader pop side and buffer status.
interface commit_trace_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          trace_valid;
  logic [31:0]   trace_pc;
  logic [31:0]   trace_result;
  logic          clear;
  logic          rd_en;
  logic          rd_valid;
  logic [31:0]   rd_pc;
  logic [31:0]   rd_result;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    drop_count;
  logic          halted;

  modport master (
    output trace_valid, trace_pc, trace_result, clear, rd_en,
    input  rd_valid, rd_pc, rd_result, empty, full, count, overflow, drop_count, halted
  );

  modport slave (
    input  trace_valid, trace_pc, trace_result, clear, rd_en,
    output rd_valid, rd_pc, rd_result, empty, full, count, overflow, drop_count, halted
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit trace FIFO: 1-cycle read latency; full drops writes (sticky overflow, counted) unless a pop frees a slot.
// TRACE_HALT_DETECT_EN adds a CAPTURE/FROZEN halt detector that freezes capture after HALT_REPEAT identical PCs.
module commit_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int HALT_REPEAT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  commit_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic          rd_vld_q;
  logic [31:0]   rd_pc_q;
  logic [31:0]   rd_result_q;
  logic          overflow_q;
  logic [7:0]    drop_q;
  logic          halted_w;

  logic is_full;
  logic is_empty;
  logic rd_ok;
  logic wr_try;
  logic wr_ok;
  logic drop;

  assign is_full  = (occ == CW'(DEPTH));
  assign is_empty = (occ == '0);
  assign rd_ok    = bus.rd_en & ~bus.clear & ~is_empty;
  assign wr_try   = bus.trace_valid & ~bus.clear & ~halted_w;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_ok    = wr_try & (~is_full | rd_ok);
  assign drop     = wr_try & is_full & ~rd_ok;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= '{pc: bus.trace_pc, result: bus.trace_result};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      rd_vld_q    <= 1'b0;
      rd_pc_q     <= '0;
      rd_result_q <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else if (bus.clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      rd_vld_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      rd_vld_q <= rd_ok;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr      <= rd_ptr + 1'b1;
        rd_pc_q     <= mem[rd_ptr].pc;
        rd_result_q <= mem[rd_ptr].result;
      end
      case ({wr_ok, rd_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
      end
    end
  end

`ifdef TRACE_HALT_DETECT_EN
  localparam int RW = $clog2(HALT_REPEAT + 1);

  typedef enum logic {CAPTURE, FROZEN} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [RW-1:0] rep_q;
  logic [RW-1:0] rep_nxt;
  logic [31:0]   last_pc_q;

  // rep_q == 0 means no PC has been accepted since reset/clear.
  assign rep_nxt = (rep_q != '0 && bus.trace_pc == last_pc_q) ? rep_q + 1'b1 : RW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CAPTURE;
      rep_q     <= '0;
      last_pc_q <= '0;
    end else if (bus.clear) begin
      state_q <= CAPTURE;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      if (wr_ok) begin
        rep_q     <= rep_nxt;
        last_pc_q <= bus.trace_pc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CAPTURE && wr_ok && rep_nxt == RW'(HALT_REPEAT)) state_d = FROZEN;
  end

  always_comb begin
    halted_w = (state_q == FROZEN);
  end
`else
  assign halted_w = 1'b0;
`endif

  assign bus.rd_valid   = rd_vld_q;
  assign bus.rd_pc      = rd_pc_q;
  assign bus.rd_result  = rd_result_q;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.count      = occ;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_q;
  assign bus.halted     = halted_w;
endmodule
